eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single RGMII transmitter among N frame sources, for example ARP reply, ICMP echo, DHCP and UDP data.
- Grants one requester at a time in round-robin order and forwards that requester's byte stream, registered, onto the transmitter's data/tx_enable inputs.
- Holds off the next grant until the transmitter deasserts active, which covers the purge and inter-frame gap.
- Guards against requesters that never start and against oversize frames.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BYTES, 1518, maximum payload bytes forwarded per frame (preamble/SFD excluded; it is added downstream).
- START_TIMEOUT, 64, clock cycles a granted requester may take before its first enable.

Ports:
- clock  in  1  125 MHz transmit clock (same clock as the transmitter's clock output).
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester frame request; level, held until grant.
- grant  out  N  one-hot grant; all zero when no requester is granted.
- data_in  in  8*N  requester byte lanes; lane i is bits [8i+7:8i].
- enable_in  in  N  per-requester byte strobe; contiguous high for the whole frame.
- tx_data  out  8  byte to the transmitter's data input.
- tx_enable  out  1  to the transmitter's tx_enable input.
- tx_active  in  1  transmitter's active output.
- busy  out  1  high in any state other than IDLE.
- timeout  out  1  one-cycle pulse: granted requester never started.
- overrun  out  1  one-cycle pulse: frame truncated at MAX_BYTES.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset values: grant=0, tx_data=0, tx_enable=0, busy=0, timeout=0, overrun=0, state=IDLE, byte count=0, timer=0.
  - Round-robin pointer last=N-1 after reset, so index 0 wins the first arbitration.
  - Reset asserted mid-frame drops tx_enable on the next edge. The transmitter then purges and gaps on its own.
- Datapath:
  - tx_data and tx_enable are registered, giving exactly 1 cycle of latency from data_in/enable_in of the granted lane.
  - Non-granted lanes are ignored entirely.
- States: IDLE, GRANT, SEND, DRAIN.
- IDLE:
  - If tx_active=0 and req!=0: select the first set req bit scanning last+1, last+2, ... modulo N.
  - Set grant to one-hot(sel), set last=sel, clear timer, go to GRANT.
  - If tx_active=1, stay in IDLE and do not grant.
- GRANT:
  - If enable_in[sel]=1: go to SEND, set tx_enable=1, tx_data=lane byte, count=1.
  - Else if req[sel]=0 (request withdrawn): grant=0, go to DRAIN. No pulse.
  - Else if timer=START_TIMEOUT-1: timeout=1 for one cycle, grant=0, go to DRAIN.
  - Else timer+1.
- SEND:
  - While enable_in[sel]=1 and count<MAX_BYTES: forward the byte and increment count.
  - enable_in[sel]=1 with count=MAX_BYTES: tx_enable=0, overrun pulse, grant=0, go to DRAIN. The remaining requester bytes are discarded.
  - enable_in[sel]=0: tx_enable=0, grant=0, go to DRAIN. The first low ends the frame; a later re-assert is not forwarded.
  - req is ignored in SEND.
- DRAIN:
  - Go to IDLE when tx_active=0. The earliest exit is the cycle after entry.
  - For a transmitted frame, tx_active stays high through the 8-byte purge plus 12-byte gap, so DRAIN lasts about 21 cycles.
  - On the timeout or withdraw paths, tx_active is already 0, so DRAIN lasts 1 cycle.
- Widths and counters:
  - count width = clog2(MAX_BYTES+1); it never wraps.
  - timer width = clog2(START_TIMEOUT).
- Grant and request rules:
  - grant is never multi-hot.
  - A requester's grant falls in the same cycle that tx_enable falls.
  - The requester deasserts req after it sees grant; a req still held on return to IDLE is a new request.
  - Simultaneous requests are resolved by the round-robin pointer only. Same-cycle arrival order is irrelevant.

Test Plan:
- Single frame: after reset, req[2]=1 → grant=0100 next cycle. enable_in[2] high for 60 bytes 0x00..0x3B → tx_data reproduces 0x00..0x3B with 1-cycle lag, tx_enable high exactly 60 cycles. grant falls with tx_enable; no new grant until tx_active falls.
- Round robin: req=1111 held continuously, each requester sends 64 bytes → grant order 0,1,2,3,0. No two grants overlap; each grant starts only after tx_active=0.
- Start timeout: req[1]=1 with enable_in[1] never high → timeout pulses once exactly 64 cycles after grant rises, grant=0, tx_enable stays 0, next requester is granted within 2 cycles.
- Overrun: requester streams 1600 bytes with MAX_BYTES=1518 → tx_enable high for exactly 1518 cycles, overrun pulses once, bytes 1519+ are not forwarded.
- Busy transmitter: tx_active forced high, req[0]=1 → grant stays 0. Release tx_active → grant=0001 the next cycle.
- Reset mid-frame: assert reset at byte 100 → next edge gives tx_enable=0, grant=0, state IDLE. After reset release with req[3]=1, grant=1000 is issued only once tx_active=0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares one RGMII transmitter among N frame sources. Requesters are granted
// one at a time in round-robin order. The granted lane's byte stream is
// forwarded through one register stage onto the transmitter's tx_data and
// tx_enable inputs. A new grant waits until the transmitter drops tx_active,
// which covers its purge and inter-frame gap. The arbiter also guards against
// a granted requester that never starts and against oversize frames.
//
// Ports:
//   clock      in   125 MHz transmit clock
//   reset      in   synchronous, active-high reset
//   req        in   [N]    per-requester frame request (level, held until grant)
//   grant      out  [N]    one-hot grant, all zero when nobody is granted
//   data_in    in   [8*N]  requester byte lanes, lane i = bits [8i+7:8i]
//   enable_in  in   [N]    per-requester byte strobe, contiguous for a frame
//   tx_data    out  [8]    registered byte to the transmitter
//   tx_enable  out         registered frame strobe to the transmitter
//   tx_active  in          transmitter busy (frame, purge or gap in progress)
//   busy       out         arbiter is in any state other than IDLE
//   timeout    out         one-cycle pulse: granted requester never started
//   overrun    out         one-cycle pulse: frame truncated at MAX_BYTES
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int N             = 4,
    parameter int MAX_BYTES     = 1518,
    parameter int START_TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    input  logic [8*N-1:0] data_in,
    input  logic [N-1:0]   enable_in,
    output logic [7:0]     tx_data,
    output logic           tx_enable,
    input  logic           tx_active,
    output logic           busy,
    output logic           timeout,
    output logic           overrun
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_BYTES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_INIT  = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SEND,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  grant_q, grant_d;
    // The round-robin pointer doubles as the current selection: it is loaded
    // with the winner at grant time and stays constant until the next grant.
    logic [SW-1:0] last, last_d;
    logic [CW-1:0] count, count_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_en_q, tx_en_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    lane [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane[i] = data_in[8*i +: 8];
    end

    // First set request bit scanning from last+1 upward, modulo N. The scan
    // runs from the farthest offset down so the nearest hit overwrites last.
    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0]  r,
                                              input logic [SW-1:0] from);
        logic [SW-1:0] pick;
        logic [SW-1:0] idx;
        pick = from;
        for (int i = N; i >= 1; i--) begin
            idx = SW'((int'(from) + i) % N);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    // State register and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            last      <= LAST_INIT;
            count     <= '0;
            timer     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_next;
            grant_q   <= grant_d;
            last      <= last_d;
            count     <= count_d;
            timer     <= timer_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        grant_d    = grant_q;
        last_d     = last;
        count_d    = count;
        timer_d    = timer;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;

        case (state)
            IDLE: begin
                if (!tx_active && (req != '0)) begin
                    last_d          = rr_pick(req, last);
                    grant_d         = '0;
                    grant_d[last_d] = 1'b1;
                    timer_d         = '0;
                    state_next      = GRANT;
                end
            end

            GRANT: begin
                if (enable_in[last]) begin
                    tx_en_d    = 1'b1;
                    tx_data_d  = lane[last];
                    count_d    = CW'(1);
                    state_next = SEND;
                end else if (!req[last]) begin
                    // Request withdrawn before starting: release quietly.
                    grant_d    = '0;
                    state_next = DRAIN;
                end else if (timer == TIMER_LAST) begin
                    timeout_d  = 1'b1;
                    grant_d    = '0;
                    state_next = DRAIN;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            SEND: begin
                if (enable_in[last]) begin
                    if (count == COUNT_MAX) begin
                        // Frame already at the limit: cut it; the rest of the
                        // requester's bytes are dropped.
                        overrun_d  = 1'b1;
                        grant_d    = '0;
                        state_next = DRAIN;
                    end else begin
                        tx_en_d   = 1'b1;
                        tx_data_d = lane[last];
                        count_d   = count + 1'b1;
                    end
                end else begin
                    // First low strobe ends the frame; grant falls together
                    // with tx_enable.
                    grant_d    = '0;
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (!tx_active) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        grant     = grant_q;
        tx_data   = tx_data_q;
        tx_enable = tx_en_q;
        busy      = (state != IDLE);
        timeout   = timeout_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
//
// Scoreboard bench for eth_tx_arbiter. Expected bytes and expected grant
// indices are queued when stimulus is driven and popped when the DUT shows
// them. A small transmitter model holds tx_active high while tx_enable is
// high and for 20 cycles afterwards (8-byte purge plus 12-byte gap).
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;

    localparam int N             = 4;
    localparam int MAX_BYTES     = 1518;
    localparam int START_TIMEOUT = 64;
    localparam int GAP_CYCLES    = 20;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [8*N-1:0] data_in;
    logic [N-1:0]   enable_in;
    logic [7:0]     tx_data;
    logic           tx_enable;
    logic           tx_active;
    logic           busy;
    logic           timeout;
    logic           overrun;

    eth_tx_arbiter #(
        .N             (N),
        .MAX_BYTES     (MAX_BYTES),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .data_in   (data_in),
        .enable_in (enable_in),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_active (tx_active),
        .busy      (busy),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #4 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] exp_bytes [$];
    int         exp_grants [$];

    logic         prev_txen    = 1'b0;
    logic [N-1:0] prev_grant   = '0;
    int           en_run       = 0;
    int           last_run     = 0;
    int           ov_cnt       = 0;
    int           to_cnt       = 0;
    int           grant_rises  = 0;
    int           gap          = 0;
    logic         force_active = 1'b0;
    logic         model_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gidx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Runs at every falling edge: score outputs, then advance the transmitter.
    task automatic monitor();
        cyc++;
        if (tx_enable) begin
            en_run++;
            check("byte_pending", 32'(exp_bytes.size() != 0), 1);
            if (exp_bytes.size() != 0) check("tx_data", tx_data, exp_bytes.pop_front());
        end else if (prev_txen) begin
            last_run = en_run;
            en_run   = 0;
            check("grant_falls_with_enable", grant, 0);
        end
        if (prev_grant == '0 && grant != '0) begin
            grant_rises++;
            check("grant_onehot", 32'($onehot(grant)), 1);
            // tx_active here is still the value the DUT sampled at the edge.
            check("grant_only_when_tx_idle", tx_active, 0);
            if (exp_grants.size() != 0) check("grant_order", gidx(grant), exp_grants.pop_front());
        end
        ov_cnt += int'(overrun);
        to_cnt += int'(timeout);
        prev_txen  = tx_enable;
        prev_grant = grant;

        if (tx_enable) begin
            model_active = 1'b1;
            gap = GAP_CYCLES;
        end else if (gap > 0) begin
            gap--;
            model_active = 1'b1;
        end else begin
            model_active = 1'b0;
        end
        tx_active = model_active | force_active;
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
    endtask

    task automatic wait_any_grant(input string tag);
        int budget;
        budget = 300;
        while (grant == '0 && budget > 0) begin
            tick();
            budget--;
        end
        if (grant == '0) check(tag, grant, 1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 300;
        while ((busy || tx_active) && budget > 0) begin
            tick();
            budget--;
        end
        if (busy || tx_active) check("wait_idle", {busy, tx_active}, 0);
    endtask

    // Drive nbytes on lane idx starting at the current falling edge.
    task automatic stream(input int idx, input int nbytes, input int base);
        for (int k = 0; k < nbytes; k++) begin
            enable_in[idx]       = 1'b1;
            data_in[8*idx +: 8]  = 8'(base + k);
            if (k < MAX_BYTES) exp_bytes.push_back(8'(base + k));
            tick();
        end
        enable_in = '0;
        data_in   = '0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int rises0;
        reset     = 1'b1;
        req       = '0;
        enable_in = '0;
        data_in   = '0;
        tx_active = 1'b0;
        tick();
        tick();
        check("rst_grant",     grant, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_tx_data",   tx_data, 0);
        check("rst_busy",      busy, 0);
        check("rst_timeout",   timeout, 0);
        check("rst_overrun",   overrun, 0);
        reset = 1'b0;

        // Single frame of 60 bytes on lane 2.
        req = 4'b0100;
        exp_grants.push_back(2);
        tick();
        check("t1_grant", grant, 4'b0100);
        req = '0;
        stream(2, 60, 0);
        check("t1_len", last_run, 60);
        wait_idle();

        // Round robin with every request held: order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) exp_grants.push_back(f % N);
        for (int f = 0; f < 5; f++) begin
            int idx;
            wait_any_grant("rr_grant_wait");
            idx = gidx(grant);
            if (f == 4) req = '0;
            if (idx >= 0) stream(idx, 64, 16 * f);
            check("rr_len", last_run, 64);
        end
        wait_idle();

        // Start timeout on lane 1, then lane 2 follows two cycles later.
        req = 4'b0010;
        exp_grants.push_back(1);
        wait_any_grant("to_grant_wait");
        c0  = cyc;
        req = 4'b0110;
        exp_grants.push_back(2);
        for (int b = 0; b < 200 && !timeout; b++) tick();
        check("to_delay", cyc - c0, START_TIMEOUT);
        check("to_grant_dropped", grant, 0);
        check("to_no_enable", tx_enable, 0);
        c0 = cyc;
        wait_any_grant("to_next_wait");
        check("to_next_delay", cyc - c0, 2);
        check("to_next_grant", grant, 4'b0100);
        req = '0;
        stream(2, 4, 8'hA0);
        check("to_pulses", to_cnt, 1);
        wait_idle();

        // Overrun: 1600 bytes offered, MAX_BYTES forwarded.
        req = 4'b0001;
        exp_grants.push_back(0);
        wait_any_grant("ov_grant_wait");
        req = '0;
        stream(0, 1600, 0);
        check("ov_len", last_run, MAX_BYTES);
        check("ov_pulses", ov_cnt, 1);
        wait_idle();

        // Busy transmitter holds off the grant.
        force_active = 1'b1;
        tx_active    = 1'b1;
        req          = 4'b0001;
        rises0       = grant_rises;
        for (int b = 0; b < 10; b++) tick();
        check("busy_no_grant", grant, 0);
        check("busy_no_rise", grant_rises - rises0, 0);
        exp_grants.push_back(0);
        force_active = 1'b0;
        tx_active    = 1'b0;
        tick();
        check("busy_release_grant", grant, 4'b0001);
        req = '0;
        stream(0, 8, 8'h50);
        wait_idle();

        // Reset in the middle of a frame.
        req = 4'b0001;
        exp_grants.push_back(0);
        wait_any_grant("rm_grant_wait");
        req = '0;
        for (int k = 0; k < 100; k++) begin
            enable_in[0]  = 1'b1;
            data_in[7:0]  = 8'(k + 3);
            exp_bytes.push_back(8'(k + 3));
            tick();
        end
        data_in[7:0] = 8'hEE;
        reset = 1'b1;
        tick();
        check("rm_tx_enable", tx_enable, 0);
        check("rm_grant", grant, 0);
        check("rm_busy", busy, 0);
        enable_in = '0;
        data_in   = '0;
        req       = 4'b1000;
        exp_grants.push_back(3);
        reset = 1'b0;
        wait_any_grant("rm_next_wait");
        check("rm_next_grant", grant, 4'b1000);
        req = '0;
        stream(3, 4, 8'h70);
        wait_idle();

        check("left_bytes",  exp_bytes.size(), 0);
        check("left_grants", exp_grants.size(), 0);
        check("total_grants", grant_rises, 12);
        check("total_timeouts", to_cnt, 1);
        check("total_overruns", ov_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
